// File: rtl/cordic_pkg.sv
// Shared CORDIC types: Q16.16 data width and the two-word result beat.
// Used by cordic_ip and its output buffer so both agree on beat layout.
package cordic_pkg;

    localparam int CORDIC_DW   = 32;
    localparam int CORDIC_FRAC = 16;

    typedef struct packed {
        logic signed [CORDIC_DW-1:0] result1;
        logic signed [CORDIC_DW-1:0] result2;
    } cordic_res_t;

endpackage

// File: rtl/cordic_sdp_ram.sv
// Simple dual-port storage for cordic_out_buf: one write port, one read port.
// Latency: read data registered, valid one edge after raddr; no backpressure.
// Array itself is never reset; only the read register clears on rst_n.
module cordic_sdp_ram
    import cordic_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  cordic_res_t       wdata,
    input  logic [AW-1:0]     raddr,
    output cordic_res_t       rdata
);

    localparam int DEPTH = 1 << AW;

    cordic_res_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cordic_out_buf.sv
// First-word-fall-through result buffer behind the CORDIC pipeline.
// Latency: a beat written into an empty buffer is at the head one edge later.
// Backpressure: almost_full leaves PIPELINE slots of slack; a beat arriving at
// full without a pop is dropped and flags ovf. CORDIC_OUT_BUF_DROP_CNT_EN adds drop_cnt.
module cordic_out_buf
    import cordic_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int PIPELINE = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        post_valid,
    input  logic signed [CORDIC_DW-1:0] result1,
    input  logic signed [CORDIC_DW-1:0] result2,
    input  logic                        clr,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic signed [CORDIC_DW-1:0] m_result1,
    output logic signed [CORDIC_DW-1:0] m_result2,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        almost_full,
    output logic                        ovf
`ifdef CORDIC_OUT_BUF_DROP_CNT_EN
    ,
    output logic [15:0]                 drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_THR  = (AW+1)'(DEPTH - PIPELINE);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   rd_ptr_nxt;
    logic [AW:0]   level_q;
    logic [AW-1:0] raddr;
    logic          ovf_q;
    logic          fwd_q;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic          drop;
    cordic_res_t   wdata;
    cordic_res_t   byp_q;
    cordic_res_t   ram_q;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop      = !empty && m_ready && !clr;
    assign push_req = post_valid && !clr;
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // RAM is read one entry ahead so the next head is already registered when a pop lands.
    assign rd_ptr_nxt = pop ? rd_ptr + PTR_ONE : rd_ptr;
    assign raddr      = rd_ptr_nxt[AW-1:0];

    always_comb begin
        wdata         = '0;
        wdata.result1 = result1;
        wdata.result2 = result2;
    end

    cordic_sdp_ram #(
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            fwd_q   <= 1'b0;
            byp_q   <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            fwd_q   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                byp_q  <= wdata;
            end
            rd_ptr <= rd_ptr_nxt;
            // Written word becomes the head this edge: RAM read returns stale data, use the copy.
            fwd_q  <= push_ok && (wr_ptr[AW-1:0] == raddr);
            if (push_ok && !pop) begin
                level_q <= level_q + PTR_ONE;
            end else if (!push_ok && pop) begin
                level_q <= level_q - PTR_ONE;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign m_valid     = !empty;
    assign m_result1   = fwd_q ? byp_q.result1 : ram_q.result1;
    assign m_result2   = fwd_q ? byp_q.result2 : ram_q.result2;
    assign level       = level_q;
    assign almost_full = (level_q >= AF_THR);
    assign ovf         = ovf_q;

`ifdef CORDIC_OUT_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (clr) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cordic_out_buf.sv
// Directed bench for cordic_out_buf with a queue model checked every cycle.
// Honours CORDIC_OUT_BUF_DROP_CNT_EN when the design is built with it.
module tb_cordic_out_buf;

    localparam int DEPTH    = 32;
    localparam int PIPELINE = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        post_valid = 1'b0;
    logic [31:0] result1 = '0;
    logic [31:0] result2 = '0;
    logic        clr = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_valid;
    logic [31:0] m_result1;
    logic [31:0] m_result2;
    logic [5:0]  level;
    logic        almost_full;
    logic        ovf;
`ifdef CORDIC_OUT_BUF_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    bit [63:0] mq[$];
    bit        m_ovf;
    int        m_drops;

    always #5 clk = ~clk;

    cordic_out_buf #(
        .DEPTH    (DEPTH),
        .PIPELINE (PIPELINE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .post_valid  (post_valid),
        .result1     (result1),
        .result2     (result2),
        .clr         (clr),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_result1   (m_result1),
        .m_result2   (m_result2),
        .level       (level),
        .almost_full (almost_full),
        .ovf         (ovf)
`ifdef CORDIC_OUT_BUF_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue model: pop first, then accept the beat if there is room, else drop it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else if (clr) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            if (mq.size() > 0 && m_ready) void'(mq.pop_front());
            if (post_valid) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back({result1, result2});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_m_valid", m_valid, mq.size() > 0);
            check("cyc_level", level, mq.size());
            check("cyc_almost_full", almost_full, mq.size() >= DEPTH - PIPELINE);
            check("cyc_ovf", ovf, m_ovf);
`ifdef CORDIC_OUT_BUF_DROP_CNT_EN
            check("cyc_drop_cnt", drop_cnt, m_drops);
`endif
            if (mq.size() > 0) begin
                check("cyc_m_result1", m_result1, mq[0][63:32]);
                check("cyc_m_result2", m_result2, mq[0][31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r1, input logic [31:0] r2);
        post_valid = v;
        result1    = r1;
        result2    = r2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_m_valid", m_valid, 0);
        check("rst_level", level, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_ovf", ovf, 0);
        check("rst_m_result1", m_result1, 0);
        check("rst_m_result2", m_result2, 0);
        check_en = 1'b1;

        // Single beat cos30/sin30 with m_ready held high.
        m_ready = 1'b1;
        drive(1'b1, 32'h0000DDB3, 32'h00008000);
        step();
        drive(1'b0, '0, '0);
        check("single_valid", m_valid, 1);
        check("single_r1", m_result1, 32'h0000DDB3);
        check("single_r2", m_result2, 32'h00008000);
        step();
        check("single_gone", m_valid, 0);
        check("single_level", level, 0);

        // Burst of five with the sink stalled, then drain.
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 32'(i), 32'(i) << 16);
            step();
        end
        drive(1'b0, '0, '0);
        check("burst_level", level, 5);
        step();
        check("burst_stall_r1", m_result1, 1);
        m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            check("burst_valid", m_valid, 1);
            check("burst_r1", m_result1, i);
            check("burst_r2", m_result2, i << 16);
            step();
        end
        check("burst_empty", m_valid, 0);
        check("burst_level0", level, 0);

        // Fill to the almost-full threshold, then to full.
        m_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 32'(100 + i), 32'(i));
            step();
            if (i == 14) check("af_before", almost_full, 0);
            if (i == 15) check("af_after", almost_full, 1);
        end
        drive(1'b0, '0, '0);
        check("full_level", level, 32);
        check("full_ovf", ovf, 0);

        // Overflow: three drops at full, head untouched, then flush.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(900 + i), 32'hDEAD);
            step();
        end
        drive(1'b0, '0, '0);
        check("ovf_set", ovf, 1);
        check("ovf_level", level, 32);
        check("ovf_head", m_result1, 100);
`ifdef CORDIC_OUT_BUF_DROP_CNT_EN
        check("ovf_drop_cnt", drop_cnt, 3);
`endif
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_level", level, 0);
        check("clr_ovf", ovf, 0);
        check("clr_valid", m_valid, 0);
`ifdef CORDIC_OUT_BUF_DROP_CNT_EN
        check("clr_drop_cnt", drop_cnt, 0);
`endif

        // Simultaneous push and pop at full, across the pointer wrap.
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 32'(200 + i), 32'(~i));
            step();
        end
        check("pp_fill", level, 32);
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(300 + i), 32'h5555);
            check("pp_head", m_result1, 200 + i);
            step();
            check("pp_level", level, 32);
            check("pp_ovf", ovf, 0);
        end
        drive(1'b0, '0, '0);
        for (int k = 0; k < 32; k++) begin
            check("pp_order", m_result1, (k < 22) ? 210 + k : 300 + (k - 22));
            step();
        end
        check("pp_drained", m_valid, 0);

        // Asynchronous reset at level 7, then a fresh first word.
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'(500 + i), 32'h0);
            step();
        end
        drive(1'b0, '0, '0);
        check("mid_level7", level, 7);
        rst_n = 1'b0;
        #1;
        check("arst_valid", m_valid, 0);
        check("arst_level", level, 0);
        #2 rst_n = 1'b1;
        drive(1'b1, 32'd600, 32'd601);
        m_ready = 1'b1;
        step();
        drive(1'b0, '0, '0);
        check("post_rst_valid", m_valid, 1);
        check("post_rst_r1", m_result1, 600);
        check("post_rst_r2", m_result2, 601);
        step();
        check("post_rst_empty", m_valid, 0);

        @(negedge clk);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cordic_out_buf.md
CORDIC_OUT_BUF -- requirements
Module: cordic_out_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 32, FIFO entries; power of two, at least 4.
REQ-002 SHALL have parameter PIPELINE, default 16, number of result beats the upstream CORDIC can still have in flight; must satisfy PIPELINE < DEPTH.
REQ-003 SHALL have port clk, input, 1 bit, the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port post_valid, input, 1 bit, result beat from the CORDIC stage.
REQ-006 SHALL have port result1, input, 32 bits, signed Q16.16 first result (cos/atan/cosh/atanh).
REQ-007 SHALL have port result2, input, 32 bits, signed Q16.16 second result (sin/-/sinh/-).
REQ-008 SHALL have port clr, input, 1 bit, synchronous flush.
REQ-009 SHALL have port m_valid, output, 1 bit, the head word is valid.
REQ-010 SHALL have port m_ready, input, 1 bit, downstream accepts the head word.
REQ-011 SHALL have port m_result1, output, 32 bits, head result1.
REQ-012 SHALL have port m_result2, output, 32 bits, head result2.
REQ-013 SHALL have port level, output, log2(DEPTH)+1 bits, current occupancy.
REQ-014 SHALL have port almost_full, output, 1 bit, upstream must deassert pre_valid.
REQ-015 SHALL have port ovf, output, 1 bit, sticky overflow flag.

Function
REQ-016 SHALL store each post_valid beat {result1,result2} in arrival order; a write takes effect on the sampling edge.
REQ-017 SHALL present a first-word-fall-through head: a beat written into an empty FIFO at edge N gives m_valid=1 with that data after edge N; there is no combinational input-to-output bypass.
REQ-018 SHALL pop the head on any edge where m_valid && m_ready; m_result1/m_result2 must stay stable while m_valid && !m_ready.
REQ-019 SHALL assert almost_full combinationally from registered level whenever level >= DEPTH-PIPELINE.
REQ-020 SHALL, when full (level==DEPTH) with post_valid && m_valid && m_ready on the same edge, perform both the pop and the push, leaving level unchanged and setting no ovf.
REQ-021 SHALL, when full with post_valid and no pop, drop the incoming beat, leave contents unchanged, and set ovf.
REQ-022 SHALL, when empty with post_valid && m_ready, only push, since m_valid is 0 before the edge.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH, with a distinct full versus empty encoding using an extra pointer bit.
REQ-024 SHALL have clr take priority over push and pop: pointers, level and ovf go to 0 and a same-cycle post_valid is discarded.
REQ-025 SHALL pass data unmodified, with no saturation or rounding.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force m_valid=0, level=0, almost_full=0, ovf=0, m_result1=m_result2=0 and both pointers to 0; the storage array is not reset.
REQ-027 SHALL, on a reset assertion mid-stream, lose all buffered beats; the first post_valid after release is treated as the first word.

Configuration
REQ-028 SHALL, with CORDIC_OUT_BUF_DROP_CNT_EN defined, add output drop_cnt[15:0]: it increments on each REQ-021 drop, saturates at 16'hFFFF, is cleared by reset and clr, and must count consecutive drops exactly.
REQ-029 SHALL, without the macro, have no drop_cnt port and no drop_cnt logic; all other behaviour is identical.

Structure
REQ-030 SHALL take from shared package cordic_pkg: CORDIC_DW=32, CORDIC_FRAC=16, typedef cordic_res_t {result1,result2}; cordic_ip and this block share them.
REQ-031 SHALL place storage in one sub-module cordic_sdp_ram (simple dual-port, one write port and one read port, registered read); the head/FWFT logic stays in cordic_out_buf.

Verification
REQ-032 SHALL cover a single beat: push {32'h0000DDB3, 32'h00008000} (cos30/sin30) into an empty FIFO with m_ready=1 -> m_valid is high for exactly 1 cycle, on the cycle after the push edge, with those values.
REQ-033 SHALL cover a burst of 5 beats 1..5 with m_ready=0 -> level=5, then m_ready=1 -> outputs 1..5 in order on consecutive cycles, m_valid drops after the 5th, level=0.
REQ-034 SHALL cover almost_full with DEPTH=32, PIPELINE=16: push 16 beats with no pop -> almost_full rises after the 16th edge; push 16 more -> level=32, ovf=0.
REQ-035 SHALL cover overflow: at full, push 3 beats with m_ready=0 -> ovf=1, level=32, drop_cnt=3 when the macro is defined, and the head is still beat 1; then clr -> level=0, ovf=0, drop_cnt=0.
REQ-036 SHALL cover push and pop at full: at level=32, post_valid with m_ready=1 for 10 cycles -> level stays 32, ovf stays 0, ordering is preserved across pointer wrap.
REQ-037 SHALL cover reset mid-stream: rst_n pulses low for 3 ns between edges at level=7 -> m_valid=0 and level=0 immediately; after release, the next beat is the first out.
